// File: rtl/fb_writer_if.sv
// Pixel stream interface between the pixel source (UART / pattern generator)
// and the frame buffer writer.
interface fb_writer_if #(
  parameter int pixel_depth = 8
);
  logic [3*pixel_depth-1:0] pix_data;
  logic                     pix_valid;
  logic                     pix_sof;
  logic                     pix_ready;

  modport master (
    output pix_data,
    output pix_valid,
    output pix_sof,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
    input  pix_sof,
    output pix_ready
  );
endinterface

// File: rtl/fb_writer.sv
// Raster-order RGB pixel stream to HUB75 frame RAM writer (row-pair word layout).
// Optional macro DOUBLE_BUFFER_EN adds a bank bit on waddr and an rd_bank output.
module fb_writer #(
  parameter int pixel_depth  = 8,
  parameter int panel_width  = 64,
  parameter int panel_height = 32,
  parameter int col_log2     = 6,
  parameter int row_log2     = 5,
  parameter int data_width   = pixel_depth * 6,
  parameter int addr_width   = 10
) (
  input  logic                  clk_in,
  input  logic                  rst,
  fb_writer_if.slave            pix,
  output logic                  we,
`ifdef DOUBLE_BUFFER_EN
  output logic [addr_width:0]   waddr,
  output logic                  rd_bank,
`else
  output logic [addr_width-1:0] waddr,
`endif
  output logic [data_width-1:0] wdata,
  output logic [1:0]            wmask,
  output logic                  frame_done,
  output logic                  sync_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [col_log2-1:0] last_col = col_log2'(panel_width - 1);
  localparam logic [row_log2-1:0] last_row = row_log2'(panel_height - 1);
  localparam logic [row_log2-1:0] half_row = row_log2'(panel_height / 2);

  state_t              state, state_n;
  logic [col_log2-1:0] col, col_n;
  logic [row_log2-1:0] row, row_n;
  logic [col_log2-1:0] wr_col;
  logic [row_log2-1:0] wr_row;
  logic                wr_n;
  logic                err_set;
  logic                accept;

  // DONE is the only cycle the writer refuses pixels; reset also holds it off.
  assign pix.pix_ready = (state != DONE) && !rst;
  assign accept        = pix.pix_valid && pix.pix_ready;

  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    wr_n    = 1'b0;
    wr_row  = row;
    wr_col  = col;
    err_set = 1'b0;
    case (state)
      IDLE: begin
        if (accept && pix.pix_sof) begin
          wr_n    = 1'b1;
          wr_row  = '0;
          wr_col  = '0;
          col_n   = col_log2'(1);
          row_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          wr_n = 1'b1;
          if (pix.pix_sof) begin
            // Resync: the partial frame is abandoned and this pixel restarts at (0,0).
            err_set = 1'b1;
            wr_row  = '0;
            wr_col  = '0;
            col_n   = col_log2'(1);
            row_n   = '0;
          end else if (row == last_row && col == last_col) begin
            col_n   = '0;
            row_n   = '0;
            state_n = DONE;
          end else if (col == last_col) begin
            col_n = '0;
            row_n = row + row_log2'(1);
          end else begin
            col_n = col + col_log2'(1);
          end
        end
      end
      DONE: begin
        col_n   = '0;
        row_n   = '0;
        state_n = IDLE;
      end
      default: begin
        col_n   = '0;
        row_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

`ifdef DOUBLE_BUFFER_EN
  logic wr_bank;

  assign rd_bank = ~wr_bank;

  // Bank flips on entry to DONE, so the new value appears alongside frame_done.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_bank <= 1'b1;
    end else if (state_n == DONE && state != DONE) begin
      wr_bank <= ~wr_bank;
    end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      wmask      <= 2'b00;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_n;
      col        <= col_n;
      row        <= row_n;
      we         <= wr_n;
      frame_done <= (state_n == DONE);
      if (err_set) begin
        sync_err <= 1'b1;
      end
      if (wr_n) begin
        // Row-pair layout: rows r and r+half share a word, so drop the row MSB.
`ifdef DOUBLE_BUFFER_EN
        waddr <= {wr_bank, addr_width'({wr_row[row_log2-2:0], wr_col})};
`else
        waddr <= addr_width'({wr_row[row_log2-2:0], wr_col});
`endif
        wmask <= (wr_row < half_row) ? 2'b10 : 2'b01;
        wdata <= {pix.pix_data, pix.pix_data};
      end
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: directed vector table plus full-frame,
// gap, resync and mid-frame reset sequences (DOUBLE_BUFFER_EN aware).
module tb_fb_writer;
  localparam int PD = 8;
  localparam int AW = 10;

  logic clk_in = 1'b0;
  logic rst;
  always #5 clk_in = ~clk_in;

  fb_writer_if #(.pixel_depth(PD)) pix ();

  logic        we;
`ifdef DOUBLE_BUFFER_EN
  logic [AW:0] waddr;
  logic        rd_bank;
`else
  logic [AW-1:0] waddr;
`endif
  logic [47:0] wdata;
  logic [1:0]  wmask;
  logic        frame_done;
  logic        sync_err;

  fb_writer dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .pix        (pix.slave),
    .we         (we),
    .waddr      (waddr),
`ifdef DOUBLE_BUFFER_EN
    .rd_bank    (rd_bank),
`endif
    .wdata      (wdata),
    .wmask      (wmask),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  typedef struct {
    logic        r;
    logic        v;
    logic        s;
    logic [23:0] d;
    logic        exp_ready;
    logic        exp_we;
    logic [9:0]  exp_addr;
    logic [1:0]  exp_mask;
    logic [47:0] exp_data;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];
  int   checks = 0;
  int   errors = 0;
  bit   exp_bank;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic v, input logic s, input logic [23:0] d);
    rst           = r;
    pix.pix_valid = v;
    pix.pix_sof   = s;
    pix.pix_data  = d;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 24'h0);
    tick();
    tick();
    exp_bank = 1'b1;
    check_output("reset_we", we, 1'b0);
    check_output("reset_waddr", waddr, 0);
    check_output("reset_done", frame_done, 1'b0);
    check_output("reset_err", sync_err, 1'b0);
`ifdef DOUBLE_BUFFER_EN
    check_output("reset_rd_bank", rd_bank, 1'b0);
`endif
    apply_stimulus(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  // Streams pixels first..first+count-1 (value = index) and checks each write.
  task automatic send_pixels(input int first, input int count, input bit sof_first);
    int          idx;
    int          row;
    int          col;
    logic [9:0]  ea;
    logic [1:0]  em;
    logic [23:0] d;
    bit          nb;
    for (int k = 0; k < count; k++) begin
      idx = first + k;
      d   = 24'(idx);
      row = idx / 64;
      col = idx % 64;
      ea  = 10'((row % 16) * 64 + col);
      em  = (row < 16) ? 2'b10 : 2'b01;
      apply_stimulus(1'b0, 1'b1, sof_first && (k == 0), d);
      tick();
      check_output("we", we, 1'b1);
      check_output("waddr", waddr[AW-1:0], ea);
      check_output("wmask", wmask, em);
      check_output("wdata", wdata, {d, d});
`ifdef DOUBLE_BUFFER_EN
      check_output("waddr_bank", waddr[AW], exp_bank);
`endif
      if (idx == 2047) begin
        exp_bank = ~exp_bank;
        nb       = ~exp_bank;
        check_output("frame_done", frame_done, 1'b1);
        check_output("ready_in_done", pix.pix_ready, 1'b0);
`ifdef DOUBLE_BUFFER_EN
        check_output("rd_bank", rd_bank, nb);
`endif
        apply_stimulus(1'b0, 1'b0, 1'b0, 24'h0);
        tick();
        check_output("done_pulse_end", frame_done, 1'b0);
        check_output("we_after_done", we, 1'b0);
        check_output("ready_after_done", pix.pix_ready, 1'b1);
      end else begin
        check_output("frame_done_early", frame_done, 1'b0);
      end
    end
  endtask

  initial begin
    apply_stimulus(1'b1, 1'b0, 1'b0, 24'h0);
    do_reset();

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 10'd0, 2'b00, 48'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 24'h111111, 1'b1, 1'b0, 10'd0, 2'b00, 48'h0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 24'h222222, 1'b1, 1'b0, 10'd0, 2'b00, 48'h0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 24'h333333, 1'b1, 1'b0, 10'd0, 2'b00, 48'h0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 24'h444444, 1'b1, 1'b0, 10'd0, 2'b00, 48'h0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 24'h555555, 1'b1, 1'b0, 10'd0, 2'b00, 48'h0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 24'hFF0000, 1'b1, 1'b1, 10'd0, 2'b10, 48'hFF0000FF0000, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 24'h00FF00, 1'b1, 1'b1, 10'd1, 2'b10, 48'h00FF0000FF00, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 24'hABCDEF, 1'b1, 1'b0, 10'd1, 2'b10, 48'h00FF0000FF00, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 24'h0000FF, 1'b1, 1'b1, 10'd2, 2'b10, 48'h0000FF0000FF, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 24'h123456, 1'b1, 1'b1, 10'd0, 2'b10, 48'h123456123456, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 10'd0, 2'b10, 48'h123456123456, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 24'h777777, 1'b0, 1'b0, 10'd0, 2'b00, 48'h0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 24'h000001, 1'b1, 1'b0, 10'd0, 2'b00, 48'h0, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].r, vecs[i].v, vecs[i].s, vecs[i].d);
      #1;
      check_output($sformatf("v%0d_ready", i), pix.pix_ready, vecs[i].exp_ready);
      tick();
      check_output($sformatf("v%0d_we", i), we, vecs[i].exp_we);
      check_output($sformatf("v%0d_waddr", i), waddr[AW-1:0], vecs[i].exp_addr);
      check_output($sformatf("v%0d_wmask", i), wmask, vecs[i].exp_mask);
      check_output($sformatf("v%0d_wdata", i), wdata, vecs[i].exp_data);
      check_output($sformatf("v%0d_done", i), frame_done, vecs[i].exp_done);
      check_output($sformatf("v%0d_err", i), sync_err, vecs[i].exp_err);
    end
    exp_bank = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 24'h0);
    tick();

    // Two back-to-back full frames.
    send_pixels(0, 2048, 1'b1);
    send_pixels(0, 2048, 1'b1);
    check_output("err_after_frames", sync_err, 1'b0);

    // Row 0 with pix_valid every other cycle.
    for (int c = 0; c < 64; c++) begin
      apply_stimulus(1'b0, 1'b1, c == 0, 24'(c + 5));
      tick();
      check_output("gap_we", we, 1'b1);
      check_output("gap_waddr", waddr[AW-1:0], 10'(c));
      apply_stimulus(1'b0, 1'b0, 1'b0, 24'h0);
      tick();
      check_output("gap_idle_we", we, 1'b0);
      check_output("gap_hold_waddr", waddr[AW-1:0], 10'(c));
    end

    // SOF re-asserted at pixel 100.
    do_reset();
    send_pixels(0, 100, 1'b1);
    send_pixels(0, 1, 1'b1);
    check_output("resync_err", sync_err, 1'b1);
    send_pixels(1, 2047, 1'b0);
    check_output("resync_err_sticky", sync_err, 1'b1);

    // Reset at pixel 500.
    do_reset();
    send_pixels(0, 500, 1'b1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 24'h5A5A5A);
    #1;
    check_output("ready_in_reset", pix.pix_ready, 1'b0);
    tick();
    check_output("we_in_reset", we, 1'b0);
    check_output("waddr_in_reset", waddr, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 24'h0);
    exp_bank = 1'b1;
    tick();
    send_pixels(0, 3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
